// File: rtl/floating_point_divider.sv
// Multi-cycle restoring floating-point divider, one quotient bit per cycle.
// FLOATING_POINT_DIVIDER_EARLY_OUT_EN: special cases skip DIVIDE/ROUND.
module floating_point_divider #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter bit ROUND_TO_NEAREST_TIES_TO_EVEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic out_valid,
  input  logic out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic underflow_flag,
  output logic overflow_flag,
  output logic invalid_operation_flag,
  output logic divide_by_zero_flag
);
  localparam int E = EXPONENT_WIDTH;
  localparam int M = MANTISSA_WIDTH;
  localparam int W = E + M + 1;
  localparam int XW = E + 2;
  localparam int CW = $clog2(M + 3);
  localparam logic signed [XW-1:0] BIAS = XW'(2 ** (E - 1) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'(2 ** E - 1);
  localparam logic signed [XW-1:0] ONE = XW'(1);
  localparam logic [CW-1:0] LAST = CW'(M + 2);
  localparam logic [M-1:0] QNAN_MAN =
    (E == 4 && M == 3) ? {M{1'b1}} : M'(1) << (M - 1);
  localparam logic [W-1:0] QNAN = {1'b1, {E{1'b1}}, QNAN_MAN};

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t state_q, state_n;
  logic accept, finish, early;

  logic [E-1:0] ea, eb;
  logic [M-1:0] ma, mb;
  logic sgn;
  logic a_zero, a_inf, a_nan, a_snan;
  logic b_zero, b_inf, b_nan, b_snan;

  logic spc, spc_inv, spc_dbz;
  logic [W-1:0] spc_res;

  logic spc_q, spc_inv_q, spc_dbz_q, sign_q, phase_q;
  logic [W-1:0] spc_res_q;
  logic signed [XW-1:0] exp_q;
  logic [M+1:0] rem_q;
  logic [M:0] div_q;
  logic [M+2:0] quo_q;
  logic [CW-1:0] cnt_q;

  logic [M+1:0] dvs, diff;
  logic ge;
  logic [M-1:0] mant, mant_r;
  logic guard, rnd, sticky, lsb, inc, carry;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0] fin_res;
  logic fin_uf, fin_of;

  assign ea = a[W-2:M];
  assign eb = b[W-2:M];
  assign ma = a[M-1:0];
  assign mb = b[M-1:0];
  assign sgn = a[W-1] ^ b[W-1];

  assign a_zero = (ea == '0);
  assign a_inf = (ea == '1) && (ma == '0);
  assign a_nan = (ea == '1) && (ma != '0);
  assign a_snan = a_nan && !ma[M-1];
  assign b_zero = (eb == '0);
  assign b_inf = (eb == '1) && (mb == '0);
  assign b_nan = (eb == '1) && (mb != '0);
  assign b_snan = b_nan && !mb[M-1];

  // Priority order matters: NaN beats 0/0 beats x/0 beats inf/x.
  always_comb begin
    spc = 1'b1;
    spc_inv = 1'b0;
    spc_dbz = 1'b0;
    spc_res = {sgn, {(W-1){1'b0}}};
    if (a_nan || b_nan) begin
      spc_res = QNAN;
      spc_inv = a_snan || b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spc_res = QNAN;
      spc_inv = 1'b1;
    end else if (b_zero && !a_inf) begin
      spc_res = {sgn, {E{1'b1}}, {M{1'b0}}};
      spc_dbz = 1'b1;
    end else if (a_inf) begin
      spc_res = {sgn, {E{1'b1}}, {M{1'b0}}};
    end else if (!a_zero && !b_inf) begin
      spc = 1'b0;
    end
  end

`ifdef FLOATING_POINT_DIVIDER_EARLY_OUT_EN
  assign early = spc_q;
`else
  assign early = 1'b0;
`endif

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept = in_valid && in_ready;
  assign finish = (state_q != DONE) && (state_n == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: if (accept) state_n = DIVIDE;
      DIVIDE: begin
        if (early) state_n = DONE;
        else if (cnt_q == LAST) state_n = ROUND;
      end
      ROUND: if (phase_q) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign dvs = {1'b0, div_q};
  assign ge = (rem_q >= dvs);
  assign diff = ge ? rem_q - dvs : rem_q;

  assign mant = quo_q[M+1:2];
  assign lsb = quo_q[2];
  assign guard = quo_q[1];
  assign rnd = quo_q[0];
  assign sticky = |rem_q;
  assign inc = ROUND_TO_NEAREST_TIES_TO_EVEN &&
               guard && (rnd || sticky || lsb);
  assign {carry, mant_r} = {1'b0, mant} + {{M{1'b0}}, inc};
  assign exp_r = carry ? exp_q + ONE : exp_q;

  always_comb begin
    fin_res = {sign_q, exp_r[E-1:0], mant_r};
    fin_uf = 1'b0;
    fin_of = 1'b0;
    if (exp_r >= EMAX) begin
      fin_res = {sign_q, {E{1'b1}}, {M{1'b0}}};
      fin_of = 1'b1;
    end else if (exp_r[XW-1] || exp_r == '0) begin
      fin_res = {sign_q, {(W-1){1'b0}}};
      fin_uf = 1'b1;
    end
    if (spc_q) begin
      fin_res = spc_res_q;
      fin_uf = 1'b0;
      fin_of = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out <= '0;
      underflow_flag <= 1'b0;
      overflow_flag <= 1'b0;
      invalid_operation_flag <= 1'b0;
      divide_by_zero_flag <= 1'b0;
    end else if (finish) begin
      out_valid <= 1'b1;
      out <= fin_res;
      underflow_flag <= fin_uf;
      overflow_flag <= fin_of;
      invalid_operation_flag <= spc_q && spc_inv_q;
      divide_by_zero_flag <= spc_q && spc_dbz_q;
    end else if (state_q == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      spc_q <= spc;
      spc_inv_q <= spc_inv;
      spc_dbz_q <= spc_dbz;
      spc_res_q <= spc_res;
      sign_q <= sgn;
      exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
      rem_q <= {2'b01, ma};
      div_q <= {1'b1, mb};
      quo_q <= '0;
      cnt_q <= '0;
      phase_q <= 1'b0;
    end else if (state_q == DIVIDE) begin
      rem_q <= diff << 1;
      quo_q <= {quo_q[M+1:0], ge};
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == ROUND && !phase_q) begin
      // Quotient in [0.5,1): renormalise before rounding.
      phase_q <= 1'b1;
      if (!quo_q[M+2]) begin
        quo_q <= quo_q << 1;
        exp_q <= exp_q - ONE;
      end
    end
  end
endmodule

// File: tb/tb_floating_point_divider.sv
// Bench for floating_point_divider: fp32, RNE and truncating instances
// checked every cycle against an integer-arithmetic reference.
module tb_floating_point_divider;
`ifdef FLOATING_POINT_DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic in_ready, out_valid, uf, of, inv, dbz;
  logic [31:0] out;
  logic in_ready_rz, out_valid_rz, uf_rz, of_rz, inv_rz, dbz_rz;
  logic [31:0] out_rz;

  bit lit_en = 1'b0;
  logic [31:0] lit_out = '0;
  logic [31:0] lit_rz = '0;
  logic [3:0] lit_flags = '0;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  floating_point_divider #(
    .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23),
    .ROUND_TO_NEAREST_TIES_TO_EVEN(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .underflow_flag(uf), .overflow_flag(of),
    .invalid_operation_flag(inv), .divide_by_zero_flag(dbz)
  );

  floating_point_divider #(
    .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23),
    .ROUND_TO_NEAREST_TIES_TO_EVEN(0)
  ) dut_rz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_rz),
    .a(a), .b(b), .out_valid(out_valid_rz), .out_ready(out_ready),
    .out(out_rz), .underflow_flag(uf_rz), .overflow_flag(of_rz),
    .invalid_operation_flag(inv_rz), .divide_by_zero_flag(dbz_rz)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Flags packed as {underflow, overflow, invalid, divide_by_zero}.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input bit rne, output logic [31:0] r,
                                output logic [3:0] f, output bit sp);
    logic [7:0] ex, ey;
    logic [22:0] mx, my;
    logic s;
    bit xn, yn, xs, ys, xi, yi, xz, yz, g, st;
    longint na, nb, q, rm, sig;
    int e;
    ex = x[30:23]; ey = y[30:23];
    mx = x[22:0]; my = y[22:0];
    s = x[31] ^ y[31];
    xn = (ex == 8'hFF) && (mx != 0); yn = (ey == 8'hFF) && (my != 0);
    xs = xn && !mx[22]; ys = yn && !my[22];
    xi = (ex == 8'hFF) && (mx == 0); yi = (ey == 8'hFF) && (my == 0);
    xz = (ex == 0); yz = (ey == 0);
    f = '0; sp = 1'b1; r = {s, 31'b0};
    if (xn || yn) begin r = 32'hFFC00000; f[1] = xs || ys; end
    else if ((xz && yz) || (xi && yi)) begin r = 32'hFFC00000; f[1] = 1'b1; end
    else if (yz && !xi) begin r = {s, 8'hFF, 23'b0}; f[0] = 1'b1; end
    else if (xi) r = {s, 8'hFF, 23'b0};
    else if (xz || yi) r = {s, 31'b0};
    else begin
      sp = 1'b0;
      na = longint'({1'b1, mx});
      nb = longint'({1'b1, my});
      q = (na << 26) / nb;
      rm = (na << 26) % nb;
      e = int'(ex) - int'(ey) + 127;
      if (q >= (longint'(1) << 26)) begin
        sig = q >> 3; g = q[2]; st = (q[1:0] != 0) || (rm != 0);
      end else begin
        sig = q >> 2; g = q[1]; st = q[0] || (rm != 0); e = e - 1;
      end
      if (rne && g && (st || sig[0])) sig++;
      if (sig == (longint'(1) << 24)) begin sig = sig >> 1; e++; end
      if (e >= 255) begin r = {s, 8'hFF, 23'b0}; f[2] = 1'b1; end
      else if (e <= 0) begin r = {s, 31'b0}; f[3] = 1'b1; end
      else r = {s, e[7:0], sig[22:0]};
    end
  endfunction

  int cyc = 0;
  int acc_cyc = 0;
  int lat_q = 0;
  bit busy = 1'b0;
  bit prev_rst = 1'b0;
  bit ev, m_lit, sp_q;
  logic [31:0] m_out, m_rz, m_lit_out, m_lit_rz;
  logic [3:0] m_f, m_frz, m_lit_f;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("in_ready_in_reset", in_ready, 0);
      if (prev_rst) begin
        chk("out_valid_reset", out_valid, 0);
        chk("out_reset", out, 0);
        chk("flags_reset", {uf, of, inv, dbz}, 0);
      end
      busy = 1'b0;
    end else begin
      chk("in_ready", in_ready, !busy);
      chk("in_ready_rz", in_ready_rz, !busy);
      ev = busy && (cyc >= acc_cyc + 1 + lat_q);
      chk("out_valid", out_valid, ev);
      chk("out_valid_rz", out_valid_rz, ev);
      if (ev) begin
        chk("out", out, m_out);
        chk("flags", {uf, of, inv, dbz}, m_f);
        chk("out_rz", out_rz, m_rz);
        chk("flags_rz", {uf_rz, of_rz, inv_rz, dbz_rz}, m_frz);
        if (m_lit) begin
          chk("lit_out", out, m_lit_out);
          chk("lit_out_rz", out_rz, m_lit_rz);
          chk("lit_flags", {uf, of, inv, dbz}, m_lit_f);
        end
      end
      if (ev && out_ready) begin
        busy = 1'b0;
      end else if (!busy && in_valid) begin
        busy = 1'b1;
        acc_cyc = cyc;
        model(a, b, 1'b1, m_out, m_f, sp_q);
        model(a, b, 1'b0, m_rz, m_frz, sp_q);
        lat_q = (sp_q && EARLY) ? 1 : 28;
        m_lit = lit_en;
        m_lit_out = lit_out;
        m_lit_rz = lit_rz;
        m_lit_f = lit_flags;
      end
    end
    prev_rst = rst;
  end

  task automatic op(input logic [31:0] x, input logic [31:0] y,
                    input bit le, input logic [31:0] lo,
                    input logic [31:0] lrz, input logic [3:0] lf,
                    input int hold, input bit pre);
    int n;
    bit acc;
    a = x; b = y;
    lit_en = le; lit_out = lo; lit_rz = lrz; lit_flags = lf;
    out_ready = pre;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!pre) begin
      repeat (hold + 1) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic reset_mid();
    a = 32'h40C00000;
    b = 32'h40000000;
    lit_en = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    op(32'h40C00000, 32'h40000000, 1, 32'h40400000, 32'h40400000, 4'b0000, 0, 0);
    op(32'h3F800000, 32'h40400000, 1, 32'h3EAAAAAB, 32'h3EAAAAAA, 4'b0000, 0, 0);
    op(32'h3F800000, 32'h00000000, 1, 32'h7F800000, 32'h7F800000, 4'b0001, 0, 0);
    op(32'h00000000, 32'h00000000, 1, 32'hFFC00000, 32'hFFC00000, 4'b0010, 0, 0);
    op(32'h7F7FFFFF, 32'h3F000000, 1, 32'h7F800000, 32'h7F800000, 4'b0100, 0, 0);
    op(32'h00800000, 32'h40000000, 1, 32'h00000000, 32'h00000000, 4'b1000, 0, 0);
    op(32'h40C00000, 32'h40000000, 1, 32'h40400000, 32'h40400000, 4'b0000, 5, 0);
    op(32'h7FC00000, 32'h3F800000, 1, 32'hFFC00000, 32'hFFC00000, 4'b0000, 0, 1);
    op(32'h7F800001, 32'h3F800000, 1, 32'hFFC00000, 32'hFFC00000, 4'b0010, 0, 0);
    op(32'h7F800000, 32'h7F800000, 1, 32'hFFC00000, 32'hFFC00000, 4'b0010, 0, 0);
    op(32'hFF800000, 32'h40000000, 1, 32'hFF800000, 32'hFF800000, 4'b0000, 2, 0);
    op(32'hBF800000, 32'h7F800000, 1, 32'h80000000, 32'h80000000, 4'b0000, 0, 1);
    op(32'h00000000, 32'h40A00000, 1, 32'h00000000, 32'h00000000, 4'b0000, 0, 0);
    op(32'hC0C00000, 32'h40000000, 1, 32'hC0400000, 32'hC0400000, 4'b0000, 0, 1);
    op(32'h00000001, 32'h3F800000, 1, 32'h00000000, 32'h00000000, 4'b0000, 0, 0);
    op(32'h3F800000, 32'h00000001, 1, 32'h7F800000, 32'h7F800000, 4'b0001, 0, 0);
    op(32'h7F800000, 32'h00000000, 1, 32'h7F800000, 32'h7F800000, 4'b0000, 0, 0);
    op(32'h3F800000, 32'h3F7FFFFF, 1, 32'h3F800001, 32'h3F800000, 4'b0000, 0, 0);
    op(32'h40490FDB, 32'h402DF854, 0, 32'h0, 32'h0, 4'b0000, 1, 0);
    op(32'h12345678, 32'h3456789A, 0, 32'h0, 32'h0, 4'b0000, 0, 1);
    op(32'hC2F6E979, 32'h3DCCCCCD, 0, 32'h0, 32'h0, 4'b0000, 0, 0);
    reset_mid();
    op(32'h40C00000, 32'h40000000, 1, 32'h40400000, 32'h40400000, 4'b0000, 0, 0);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d passed", npass, ntotal);
    $fatal(1, "watchdog");
  end
endmodule
